// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: requests consecutive SD sectors from the sector reader,
// then reads each 512-byte sector back out of the shared sector RAM and
// presents it as a valid/ready byte stream.
//
// Optional feature macro: SD_STREAM_LOOP_EN
//   defined     : after the last sector of a run, restart at start_sector
//                 forever (finished_out pulses once per pass; only rst stops it)
//   not defined : the run ends in DONE -> IDLE
//
// Stream handshake: byte_valid_out/byte_out are registered and held stable
// until a cycle where byte_valid_out & byte_ready_in are both high at the
// rising edge; that edge is the transfer, and valid drops on that same edge.
// Valid never drops without a transfer (except on rst).
//
// dbg_state exposes the FSM state encoding for checkers.
module sd_sector_streamer #(
  parameter int SECTOR_BYTES   = 512,
  parameter int RAM_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_in,
  input  logic [31:0]                     start_sector_in,
  input  logic [15:0]                     num_sectors_in,
  output logic [31:0]                     sd_addr_out,
  output logic                            sd_read_en_out,
  input  logic                            sd_done_in,
  input  logic                            sd_error_in,
  output logic [$clog2(SECTOR_BYTES)-1:0] ram_addr_out,
  input  logic [7:0]                      ram_dout_in,
  output logic [7:0]                      byte_out,
  output logic                            byte_valid_out,
  input  logic                            byte_ready_in,
  output logic                            busy_out,
  output logic                            finished_out,
  output logic                            error_out,
  output logic [15:0]                     sectors_done_out,
  output logic [2:0]                      dbg_state
);

  localparam int IDX_W  = $clog2(SECTOR_BYTES);
  localparam int LAT_W  = $clog2(RAM_LATENCY + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_SD  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_OUT      = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         start_q;
  logic [15:0]         num_q;
  logic [15:0]         done_q;
  logic [15:0]         done_next;
  logic [IDX_W-1:0]    idx_q;
  logic [LAT_W-1:0]    lat_q;
  logic [TOUT_W-1:0]   tout_q;
  logic [7:0]          byte_q;
  logic                valid_q;
  logic                finished_q;

  logic                start_ok;
  logic                sd_ok;
  logic                capture;
  logic                xfer;
  logic                last_byte;
  logic                run_end;
  logic                fin_d;

  assign last_byte = (idx_q == IDX_W'(SECTOR_BYTES - 1));
  assign done_next = (done_q == 16'hFFFF) ? done_q : done_q + 16'd1;
  assign run_end   = (done_next == num_q);

  // Next-state and control strobes; every output of this block defaulted first.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    sd_ok    = 1'b0;
    capture  = 1'b0;
    xfer     = 1'b0;
    fin_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_in) begin
          start_ok = 1'b1;
          if (num_sectors_in == 16'd0) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_WAIT_SD;
      S_WAIT_SD: begin
        if (sd_done_in && !sd_error_in) begin
          sd_ok   = 1'b1;
          state_d = S_RD_ISSUE;
        end else if (sd_done_in || (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d = S_ERROR;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(RAM_LATENCY - 1)) begin
          capture = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (byte_ready_in) begin
          xfer = 1'b1;
          if (!last_byte) begin
            state_d = S_RD_ISSUE;
          end else if (run_end) begin
            fin_d = 1'b1;
`ifdef SD_STREAM_LOOP_EN
            state_d = S_REQ;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus the run/sector/byte datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      num_q      <= '0;
      done_q     <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      tout_q     <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= fin_d;
      if (start_ok) begin
        start_q <= start_sector_in;
        num_q   <= num_sectors_in;
        done_q  <= '0;
      end
      if (state_q == S_REQ) begin
        tout_q <= '0;
      end else if (state_q == S_WAIT_SD) begin
        tout_q <= tout_q + TOUT_W'(1);
      end
      if (sd_ok) begin
        idx_q <= '0;
      end
      if (state_q == S_RD_ISSUE) begin
        lat_q <= '0;
      end else if (state_q == S_RD_WAIT) begin
        lat_q <= lat_q + LAT_W'(1);
      end
      if (capture) begin
        byte_q  <= ram_dout_in;
        valid_q <= 1'b1;
      end
      if (xfer) begin
        valid_q <= 1'b0;
        if (!last_byte) begin
          idx_q <= idx_q + IDX_W'(1);
        end else begin
`ifdef SD_STREAM_LOOP_EN
          done_q <= run_end ? 16'd0 : done_next;
`else
          done_q <= done_next;
`endif
        end
      end
    end
  end

  // Sector address wraps modulo 2^32 with no flag.
  assign sd_addr_out      = start_q + {16'd0, done_q};
  assign sd_read_en_out   = (state_q == S_REQ);
  assign ram_addr_out     = idx_q;
  assign byte_out         = byte_q;
  assign byte_valid_out   = valid_q;
  assign busy_out         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign finished_out     = finished_q;
  assign error_out        = (state_q == S_ERROR);
  assign sectors_done_out = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Directed bench for sd_sector_streamer with a scoreboard of expected SD
// request addresses and expected stream bytes, a 2-cycle RAM model
// (data = address low byte) and a simple SD reader model.
module tb_sd_sector_streamer;

  localparam int SB = 512;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_in;
  logic [31:0] start_sector_in;
  logic [15:0] num_sectors_in;
  logic [31:0] sd_addr_out;
  logic        sd_read_en_out;
  logic        sd_done_in;
  logic        sd_error_in;
  logic [8:0]  ram_addr_out;
  logic [7:0]  ram_dout_in;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        busy_out;
  logic        finished_out;
  logic        error_out;
  logic [15:0] sectors_done_out;
  logic [2:0]  dbg_state;

  sd_sector_streamer #(
    .SECTOR_BYTES(SB),
    .RAM_LATENCY(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .start_sector_in(start_sector_in), .num_sectors_in(num_sectors_in),
    .sd_addr_out(sd_addr_out), .sd_read_en_out(sd_read_en_out),
    .sd_done_in(sd_done_in), .sd_error_in(sd_error_in),
    .ram_addr_out(ram_addr_out), .ram_dout_in(ram_dout_in),
    .byte_out(byte_out), .byte_valid_out(byte_valid_out), .byte_ready_in(byte_ready_in),
    .busy_out(busy_out), .finished_out(finished_out), .error_out(error_out),
    .sectors_done_out(sectors_done_out), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  int total = 0;
  int bad   = 0;
  int read_cnt = 0;
  int fin_cnt  = 0;

  // model controls
  int   sd_delay   = 50;
  bit   sd_never   = 1'b0;
  int   sd_err_req = -1;
  int   req_n      = 0;
  bit   rand_ready = 1'b0;
  logic ready_level = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model: two register stages, data = low byte of address
  logic [8:0] ram_r1;
  always @(posedge clk) begin
    ram_r1      <= ram_addr_out;
    ram_dout_in <= ram_r1[7:0];
  end

  // SD reader model: done pulse sd_delay cycles after each read_en
  int sd_cnt = -1;
  always @(posedge clk) begin
    #1;
    sd_done_in  = 1'b0;
    sd_error_in = 1'b0;
    if (rst) begin
      sd_cnt = -1;
    end else if (sd_read_en_out) begin
      sd_cnt = sd_delay;
      req_n++;
    end else if (sd_cnt > 0) begin
      sd_cnt--;
    end else if (sd_cnt == 0) begin
      sd_cnt = -1;
      if (!sd_never) begin
        sd_done_in  = 1'b1;
        sd_error_in = (req_n == sd_err_req);
      end
    end
  end

  // ready driver: changes just after the active edge
  always @(posedge clk) begin
    #1;
    byte_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // output monitor: requests, finished pulses, handshakes, hold stability
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pb = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (sd_read_en_out) begin
        read_cnt++;
        if (exp_addr_q.size() == 0) check("unexpected_read_en", 32'd1, 32'd0);
        else check("sd_addr", sd_addr_out, exp_addr_q.pop_front());
      end
      if (finished_out) fin_cnt++;
      if (pv && !pr) begin
        check("hold_valid", {31'd0, byte_valid_out}, 32'd1);
        check("hold_data", {24'd0, byte_out}, {24'd0, pb});
      end
      if (byte_valid_out && byte_ready_in) begin
        if (exp_q.size() == 0) check("extra_byte", 32'd1, 32'd0);
        else check("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
    pv = byte_valid_out;
    pr = byte_ready_in;
    pb = byte_out;
  end

  // driver tasks
  task automatic push_sector();
    for (int i = 0; i < SB; i++) exp_q.push_back(8'(i));
  endtask

  task automatic do_start(input logic [31:0] s, input logic [15:0] n);
    start_sector_in = s;
    num_sectors_in  = n;
    start_in        = 1'b1;
    @(negedge clk);
    start_in        = 1'b0;
  endtask

  task automatic wait_end(input int max, input string tag);
    int n = 0;
    while (!finished_out && !error_out && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (n < max)}, 32'd1);
  endtask

  int snap_r;
  int snap_f;

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    start_sector_in = '0;
    num_sectors_in = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_fin", {31'd0, finished_out}, 32'd0);
    check("rst_err", {31'd0, error_out}, 32'd0);
    check("rst_rden", {31'd0, sd_read_en_out}, 32'd0);
    check("rst_valid", {31'd0, byte_valid_out}, 32'd0);
    check("rst_sdone", {16'd0, sectors_done_out}, 32'd0);
    check("rst_addr", sd_addr_out, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single sector at 0x100, ready always high
    exp_addr_q.push_back(32'h100);
    push_sector();
    do_start(32'h100, 16'd1);
    wait_end(5000, "t1_bound");
    check("t1_busy_done", {31'd0, busy_out}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_fin_cnt", fin_cnt, 32'd1);
    check("t1_read_cnt", read_cnt, 32'd1);
    check("t1_bytes_left", exp_q.size(), 32'd0);
    check("t1_sdone", {16'd0, sectors_done_out}, 32'd1);

    // 2: three sectors from 0x7
    sd_delay = 5;
    snap_r = read_cnt;
    for (int s = 0; s < 3; s++) begin
      exp_addr_q.push_back(32'h7 + 32'(s));
      push_sector();
    end
    do_start(32'h7, 16'd3);
    wait_end(15000, "t2_bound");
    repeat (3) @(negedge clk);
    check("t2_sdone", {16'd0, sectors_done_out}, 32'd3);
    check("t2_reads", read_cnt - snap_r, 32'd3);
    check("t2_bytes_left", exp_q.size(), 32'd0);
    check("t2_addr_left", exp_addr_q.size(), 32'd0);
    check("t2_fin_cnt", fin_cnt, 32'd2);

    // 3: random ready, stability and ordering checked by the monitor
    rand_ready = 1'b1;
    exp_addr_q.push_back(32'h20);
    push_sector();
    do_start(32'h20, 16'd1);
    wait_end(20000, "t3_bound");
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_bytes_left", exp_q.size(), 32'd0);
    check("t3_err", {31'd0, error_out}, 32'd0);

    // 4: error reported with done on the second sector
    sd_err_req = req_n + 2;
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h41);
    push_sector();
    do_start(32'h40, 16'd3);
    wait_end(5000, "t4_bound");
    @(negedge clk);
    check("t4_err", {31'd0, error_out}, 32'd1);
    check("t4_sdone", {16'd0, sectors_done_out}, 32'd1);
    check("t4_busy", {31'd0, busy_out}, 32'd0);
    check("t4_state", {29'd0, dbg_state}, 32'd7);
    snap_r = read_cnt;
    repeat (200) @(negedge clk);
    check("t4_no_more_reads", read_cnt, snap_r);
    check("t4_err_sticky", {31'd0, error_out}, 32'd1);
    check("t4_bytes_left", exp_q.size(), 32'd0);
    sd_err_req = -1;

    // 5: sd_done never arrives; timeout after 100 cycles of WAIT_SD
    sd_never = 1'b1;
    exp_addr_q.push_back(32'h80);
    do_start(32'h80, 16'd1);
    check("t5_err_cleared", {31'd0, error_out}, 32'd0);
    begin
      int n = 0;
      while (!sd_read_en_out && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t5_req_seen", {31'd0, (n < 20)}, 32'd1);
    end
    repeat (100) @(negedge clk);
    check("t5_err_before", {31'd0, error_out}, 32'd0);
    @(negedge clk);
    check("t5_err_at", {31'd0, error_out}, 32'd1);
    sd_never = 1'b0;

    // 6: rst mid-sector, then a zero-length run
    sd_delay = 10;
    exp_addr_q.push_back(32'h200);
    push_sector();
    do_start(32'h200, 16'd2);
    begin
      int n = 0;
      while (exp_q.size() > SB - 20 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("t6_partial_seen", {31'd0, (n < 3000)}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", {31'd0, busy_out}, 32'd0);
    check("t6_rst_valid", {31'd0, byte_valid_out}, 32'd0);
    check("t6_rst_err", {31'd0, error_out}, 32'd0);
    check("t6_rst_sdone", {16'd0, sectors_done_out}, 32'd0);
    check("t6_rst_addr", sd_addr_out, 32'd0);
    check("t6_rst_ram", {23'd0, ram_addr_out}, 32'd0);
    check("t6_rst_byte", {24'd0, byte_out}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    snap_r = read_cnt;
    snap_f = fin_cnt;
    do_start(32'h300, 16'd0);
    repeat (3) @(negedge clk);
    check("t6_zero_fin", fin_cnt - snap_f, 32'd1);
    check("t6_zero_reads", read_cnt, snap_r);
    check("t6_zero_busy", {31'd0, busy_out}, 32'd0);
    check("t6_addr_left", exp_addr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
